noekeon_byte_io: RTL and testbench

Byte-serial front end for the Noekeon core. It assembles 8-bit input frames into 128-bit key or data blocks and drives the core's one-cycle write strobes. It waits for the core to go idle, then streams the 128-bit result back out as 16 bytes. It sits directly upstream and downstream of the core, connected to its inKeyWr/inDataWr/inMode/inDecipher/outBusy/outData pins.

---
 rtl/noekeon_byte_io.sv | 196 +++++++++++++++++++
 tb/tb_noekeon_byte_io.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noekeon_byte_io.sv
// -----------------------------------------------------------------------------
// noekeon_byte_io
//
// Byte-serial front end for a Noekeon block-cipher core. Input frames of one
// header byte plus 16 payload bytes are assembled into a 128-bit block and
// handed to the core with a single-cycle key or data write strobe. After a data
// write, the block waits for the core to go idle and then streams the 128-bit
// result back out as 16 bytes, most significant byte first.
//
// Ports
//   inClk, inReset         clock (rising edge) and async active-high reset
//   inByteValid/inByteData input byte stream, accepted with outByteReady
//   outTxValid/outTxData   output byte stream, transferred with inTxReady
//   outCoreKeyWr           one-cycle key write strobe to the core
//   outCoreDataWr          one-cycle data write strobe to the core
//   outCoreBlock           assembled 128-bit block for the core key/data input
//   outCoreMode            0 = direct key mode, 1 = indirect key mode
//   outCoreDecipher        0 = encrypt, 1 = decrypt
//   inCoreBusy/inCoreData  core busy flag and 128-bit result
//   outBusy                a frame is in progress (not idle)
//   outKeyLoaded           a key frame has completed since reset
//   outError               one-cycle pulse when a data frame arrives before any key
//
// Header byte: bit7 = 1 key / 0 data, bit1 = mode, bit0 = decipher.
// Bits 6..2 carry no meaning and are dropped.
//
// GUARD_CYCLES (1..15) is the number of cycles after a write strobe during
// which inCoreBusy is ignored, covering the core's latency in raising busy.
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a header byte
//   ST_LOAD  | shifting in 16 payload bytes
//   ST_WRITE | single cycle: key or data write strobe to the core
//   ST_GUARD | GUARD_CYCLES cycles, core busy flag not yet trusted
//   ST_WAIT  | waiting for the core to drop busy
//   ST_SEND  | streaming the 16 result bytes out
// -----------------------------------------------------------------------------
module noekeon_byte_io #(
    parameter int GUARD_CYCLES = 1
) (
    input  logic         inClk,
    input  logic         inReset,
    input  logic         inByteValid,
    input  logic [7:0]   inByteData,
    output logic         outByteReady,
    output logic         outTxValid,
    output logic [7:0]   outTxData,
    input  logic         inTxReady,
    output logic         outCoreKeyWr,
    output logic         outCoreDataWr,
    output logic [127:0] outCoreBlock,
    output logic         outCoreMode,
    output logic         outCoreDecipher,
    input  logic         inCoreBusy,
    input  logic [127:0] inCoreData,
    output logic         outBusy,
    output logic         outKeyLoaded,
    output logic         outError
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_SEND  = 3'd5;

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES);
    localparam logic [3:0] LAST_BYTE  = 4'd15;

    logic [2:0]   state;
    logic [3:0]   byte_cnt;
    logic [3:0]   guard_cnt;
    logic         frame_is_key;
    logic         core_mode;
    logic         core_decipher;
    logic [127:0] core_block;
    logic [127:0] tx_reg;
    logic         key_loaded;
    logic         error_pulse;

    logic         in_fire;
    logic         tx_fire;

    assign outByteReady    = (state == ST_IDLE) || (state == ST_LOAD);
    assign outTxValid      = (state == ST_SEND);
    assign outTxData       = tx_reg[127:120];
    assign outCoreKeyWr    = (state == ST_WRITE) &&  frame_is_key;
    assign outCoreDataWr   = (state == ST_WRITE) && !frame_is_key;
    assign outCoreBlock    = core_block;
    assign outCoreMode     = core_mode;
    assign outCoreDecipher = core_decipher;
    assign outBusy         = (state != ST_IDLE);
    assign outKeyLoaded    = key_loaded;
    assign outError        = error_pulse;

    assign in_fire = inByteValid && outByteReady;
    assign tx_fire = outTxValid && inTxReady;

    // Frame sequencing. byte_cnt is shared between LOAD and SEND since the
    // two phases never overlap; it wraps 15 -> 0 on its own, so it is back at
    // zero whenever either phase finishes.
    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            state         <= ST_IDLE;
            byte_cnt      <= 4'd0;
            guard_cnt     <= 4'd0;
            frame_is_key  <= 1'b0;
            core_mode     <= 1'b0;
            core_decipher <= 1'b0;
            core_block    <= 128'd0;
            tx_reg        <= 128'd0;
            key_loaded    <= 1'b0;
            error_pulse   <= 1'b0;
        end else begin
            error_pulse <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        frame_is_key  <= inByteData[7];
                        core_mode     <= inByteData[1];
                        core_decipher <= inByteData[0];
                        byte_cnt      <= 4'd0;
                        state         <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (in_fire) begin
                        // Big-endian: first payload byte ends up in [127:120].
                        core_block <= {core_block[119:0], inByteData};
                        byte_cnt   <= byte_cnt + 4'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            // Encrypting or decrypting without a key would
                            // hand back garbage, so the frame is dropped.
                            if (!frame_is_key && !key_loaded) begin
                                error_pulse <= 1'b1;
                                state       <= ST_IDLE;
                            end else begin
                                state <= ST_WRITE;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    guard_cnt <= GUARD_LOAD;
                    state     <= ST_GUARD;
                end

                ST_GUARD: begin
                    // Down-counter; terminal count at 1 gives exactly
                    // GUARD_LOAD cycles in this state.
                    if (guard_cnt <= 4'd1) begin
                        state <= ST_WAIT;
                    end else begin
                        guard_cnt <= guard_cnt - 4'd1;
                    end
                end

                ST_WAIT: begin
                    if (!inCoreBusy) begin
                        if (frame_is_key) begin
                            key_loaded <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            // Result is captured once; the core output may
                            // change freely while the bytes drain.
                            tx_reg   <= inCoreData;
                            byte_cnt <= 4'd0;
                            state    <= ST_SEND;
                        end
                    end
                end

                ST_SEND: begin
                    if (tx_fire) begin
                        tx_reg   <= {tx_reg[119:0], 8'h00};
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noekeon_byte_io.sv
// -----------------------------------------------------------------------------
// Testbench for noekeon_byte_io. A small core stand-in answers the write
// strobes; a frame-level model predicts strobes, error pulses and output bytes,
// and one compare process checks the DUT against it on every cycle.
// -----------------------------------------------------------------------------
module tb_noekeon_byte_io;

    localparam int G = 3;

    localparam logic [127:0] C_DIR = 128'h503d2dfc_24b70148_699e29fa_b1656851;
    localparam logic [127:0] C_IND = 128'hf678178b_99a99f08_9299c716_ba693381;
    localparam logic [127:0] K1    = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] B1    = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B2    = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
    localparam logic [127:0] JUNK  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    logic         clk = 1'b0;
    logic         rst;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_ready;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic         tx_ready = 1'b1;
    logic         core_key_wr;
    logic         core_data_wr;
    logic [127:0] core_block;
    logic         core_mode;
    logic         core_decipher;
    logic         core_busy;
    logic [127:0] core_data;
    logic         busy;
    logic         key_loaded;
    logic         error;

    noekeon_byte_io #(.GUARD_CYCLES(G)) dut (
        .inClk          (clk),
        .inReset        (rst),
        .inByteValid    (byte_valid),
        .inByteData     (byte_data),
        .outByteReady   (byte_ready),
        .outTxValid     (tx_valid),
        .outTxData      (tx_data),
        .inTxReady      (tx_ready),
        .outCoreKeyWr   (core_key_wr),
        .outCoreDataWr  (core_data_wr),
        .outCoreBlock   (core_block),
        .outCoreMode    (core_mode),
        .outCoreDecipher(core_decipher),
        .inCoreBusy     (core_busy),
        .inCoreData     (core_data),
        .outBusy        (busy),
        .outKeyLoaded   (key_loaded),
        .outError       (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cipher behaviour as seen through the byte interface: the known Noekeon
    // vectors for the all-zero key, and an arbitrary keyed scramble otherwise
    // (good enough to expose byte ordering and mode/direction routing).
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic m,
                                             input logic d, input logic [127:0] b);
        if (k == 128'd0 && !m && !d && b == 128'd0) return C_DIR;
        if (k == 128'd0 && !m &&  d && b == C_DIR)  return 128'd0;
        if (k == 128'd0 &&  m && !d && b == 128'd0) return C_IND;
        if (k == 128'd0 &&  m &&  d && b == C_IND)  return 128'd0;
        return {b[119:0], b[127:120]} ^ k ^ {64'd0, 62'd0, m, d};
    endfunction

    // ---------------- core stand-in ----------------
    // Busy rises 3 cycles after the strobe (inside the G=3 guard window) and
    // stays up for busy_len cycles. The result is only presented after busy
    // drops and is replaced with junk once the bytes start draining.
    int           busy_len = 4;
    logic         stub_active = 1'b0;
    int           stub_t = 0;
    logic         stub_sent = 1'b0;
    logic [127:0] stub_key = '0;
    logic [127:0] stub_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_active <= 1'b0;
            stub_t      <= 0;
            stub_sent   <= 1'b0;
        end else if (core_key_wr || core_data_wr) begin
            stub_active <= 1'b1;
            stub_t      <= 1;
            stub_sent   <= 1'b0;
            if (core_key_wr) stub_key <= core_block;
            else stub_res <= core_fn(stub_key, core_mode, core_decipher, core_block);
        end else if (stub_active) begin
            if (stub_t < 10000) stub_t <= stub_t + 1;
            if (tx_valid) stub_sent <= 1'b1;
        end
    end

    assign core_busy = stub_active && stub_t >= 3 && stub_t < 3 + busy_len;
    assign core_data = (stub_active && stub_t >= 3 + busy_len && !stub_sent) ? stub_res : JUNK;

    // ---------------- frame-level model ----------------
    typedef struct {
        logic         is_key;
        logic         mode;
        logic         dec;
        logic [127:0] blk;
    } strobe_t;

    strobe_t      st_q[$];
    logic [7:0]   tx_q[$];
    int           err_exp = 0;
    logic [127:0] m_key = '0;
    logic         m_key_loaded = 1'b0;

    // ---------------- compare process ----------------
    int           rdy_mode = 0;
    int           rdy_idx = 0;
    logic         prev_hold = 1'b0;
    logic [7:0]   prev_data = 8'h00;
    int           err_seen = 0;
    int           rx_cnt = 0;
    logic [127:0] rx_word = '0;
    strobe_t      mon_s;

    always @(negedge clk) begin
        // Sink readiness for the coming edge: always ready, or 1,0,0 repeating.
        if (rdy_mode == 0) tx_ready = 1'b1;
        else begin
            tx_ready = (rdy_idx % 3 == 0);
            rdy_idx++;
        end

        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("tx_hold_valid", tx_valid, 1'b1);
                check("tx_hold_data", tx_data, prev_data);
            end
            if (tx_valid) check("no_input_while_sending", byte_ready, 1'b0);
            if (tx_valid && tx_ready) begin
                check("tx_expected", tx_q.size() > 0, 1'b1);
                if (tx_q.size() > 0) check("tx_byte", tx_data, tx_q.pop_front());
                rx_word = {rx_word[119:0], tx_data};
                rx_cnt++;
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;

            check("strobe_exclusive", core_key_wr && core_data_wr, 1'b0);
            if (core_key_wr || core_data_wr) begin
                check("strobe_expected", st_q.size() > 0, 1'b1);
                if (st_q.size() > 0) begin
                    mon_s = st_q.pop_front();
                    check("strobe_kind", core_key_wr, mon_s.is_key);
                    check("strobe_block", core_block, mon_s.blk);
                    check("strobe_mode", core_mode, mon_s.mode);
                    check("strobe_dec", core_decipher, mon_s.dec);
                end
            end

            if (error) begin
                check("error_expected", err_seen < err_exp, 1'b1);
                err_seen++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("byte_accept_timeout", byte_ready, 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] blk);
        strobe_t      s;
        logic [127:0] res;
        s.is_key = hdr[7];
        s.mode   = hdr[1];
        s.dec    = hdr[0];
        s.blk    = blk;
        if (hdr[7]) begin
            st_q.push_back(s);
            m_key        = blk;
            m_key_loaded = 1'b1;
        end else if (!m_key_loaded) begin
            err_exp++;
        end else begin
            st_q.push_back(s);
            res = core_fn(m_key, hdr[1], hdr[0], blk);
            for (int i = 0; i < 16; i++) tx_q.push_back(res[127 - 8*i -: 8]);
        end
        send_byte(hdr);
        for (int i = 0; i < 16; i++) send_byte(blk[127 - 8*i -: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || tx_q.size() != 0 || st_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, n < 3000, 1'b1);
        check({tag, "_key_flag"}, key_loaded, m_key_loaded);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] hdr, input logic [127:0] blk);
        send_frame(hdr, blk);
        wait_idle(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1'b1);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_key_wr"}, core_key_wr, 1'b0);
        check({tag, "_data_wr"}, core_data_wr, 1'b0);
        check({tag, "_block"}, core_block, 128'd0);
        check({tag, "_mode"}, core_mode, 1'b0);
        check({tag, "_dec"}, core_decipher, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_key_loaded"}, key_loaded, 1'b0);
        check({tag, "_error"}, error, 1'b0);
    endtask

    int rx_start;
    int n_wait;

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Data frame before any key: rejected with a single error pulse.
        rx_start = rx_cnt;
        send_frame(8'h00, 128'd0);
        n_wait = 0;
        while (!error && n_wait < 100) begin
            @(negedge clk);
            n_wait++;
        end
        check("error_seen", n_wait < 100, 1'b1);
        @(negedge clk);
        check("error_single", error, 1'b0);
        check("ready_after_error", byte_ready, 1'b1);
        check("busy_after_error", busy, 1'b0);
        check("no_key_after_error", key_loaded, 1'b0);
        repeat (5) @(negedge clk);
        check("error_count", err_seen, err_exp);
        check("no_tx_on_error", rx_cnt - rx_start, 0);

        // Zero key, direct mode.
        rx_start = rx_cnt;
        run_frame("key0", 8'h80, 128'd0);
        check("key0_no_tx", rx_cnt - rx_start, 0);
        rx_start = rx_cnt;
        run_frame("enc_dir", 8'h00, 128'd0);
        check("enc_dir_count", rx_cnt - rx_start, 16);
        check("enc_dir_literal", rx_word, 128'h503d2dfc_24b70148_699e29fa_b1656851);
        rx_start = rx_cnt;
        run_frame("dec_dir", 8'h01, C_DIR);
        check("dec_dir_count", rx_cnt - rx_start, 16);
        check("dec_dir_literal", rx_word, 128'd0);

        // Indirect mode.
        run_frame("key0_ind", 8'h82, 128'd0);
        rx_start = rx_cnt;
        run_frame("enc_ind", 8'h02, 128'd0);
        check("enc_ind_count", rx_cnt - rx_start, 16);
        check("enc_ind_literal", rx_word, 128'hf678178b_99a99f08_9299c716_ba693381);
        run_frame("dec_ind", 8'h03, C_IND);
        check("dec_ind_literal", rx_word, 128'd0);

        // Backpressure on the output, with the next key header queued behind
        // the data frame so it must wait for the last transfer.
        rdy_mode = 1;
        rx_start = rx_cnt;
        send_frame(8'h00, 128'd0);
        send_frame(8'hfc, K1);
        wait_idle("backpressure");
        rdy_mode = 0;
        check("bp_count", rx_cnt - rx_start, 16);
        check("bp_literal", rx_word, 128'h503d2dfc_24b70148_699e29fa_b1656851);

        // Non-zero key and blocks, different core busy times, junk header bits.
        busy_len = 1;
        rx_start = rx_cnt;
        run_frame("k1_b1", 8'h03, B1);
        check("k1_b1_count", rx_cnt - rx_start, 16);
        busy_len = 9;
        run_frame("k1_b2", 8'h7e, B2);
        busy_len = 4;

        // Reset in the middle of a key frame.
        send_byte(8'h80);
        for (int i = 0; i < 7; i++) send_byte(8'h11 * (i + 1));
        rst = 1'b1;
        #1;
        check_reset_outputs("midload");
        @(negedge clk);
        rst = 1'b0;
        m_key_loaded = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_midload");
        run_frame("rekey", 8'h80, 128'd0);
        rx_start = rx_cnt;
        run_frame("reenc", 8'h00, 128'd0);
        check("reenc_count", rx_cnt - rx_start, 16);
        check("reenc_literal", rx_word, 128'h503d2dfc_24b70148_699e29fa_b1656851);

        repeat (4) @(negedge clk);
        check("final_error_count", err_seen, err_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
